// File: rtl/mc_datapath_pkg.sv
// rtl/mc_datapath_pkg.sv - shared widths, control encodings and helpers for the multicycle datapath
package mc_datapath_pkg;

  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_REG    = 2'b11
  } pcsrc_t;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
    return {{(DATA_W-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mc_datapath_if.sv
// rtl/mc_datapath_if.sv - control bundle, status and memory signals between controller, datapath and memory
interface mc_datapath_if import mc_datapath_pkg::*; ;

  logic              PCLoad;
  logic              IorD;
  logic              IRWrite;
  logic              RegDst;
  logic              JalSig1;
  logic              JalSig2;
  logic              MemToReg;
  logic              RegWrite;
  logic              ALUSrcA;
  logic [1:0]        ALUSrcB;
  logic [2:0]        ALUOperation;
  logic [1:0]        PCSrc;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [5:0]        opc;
  logic [5:0]        func;
  logic              zero;

  modport master (
    output PCLoad, IorD, IRWrite, RegDst, JalSig1, JalSig2, MemToReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOperation, PCSrc, mem_rdata,
    input  mem_addr, mem_wdata, opc, func, zero
  );

  modport slave (
    input  PCLoad, IorD, IRWrite, RegDst, JalSig1, JalSig2, MemToReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOperation, PCSrc, mem_rdata,
    output mem_addr, mem_wdata, opc, func, zero
  );

endinterface

// File: rtl/mc_regfile.sv
// rtl/mc_regfile.sv - 32x32 register file, two async read ports, one sync write port, r0 hardwired to zero
module mc_regfile import mc_datapath_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        raddr_a,
  input  logic [4:0]        raddr_b,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [REG_N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // No write bypass: a same-edge read sees the old contents.
  assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mc_datapath.sv
// rtl/mc_datapath.sv - multicycle MIPS datapath: PC, IR/MDR/A/B/ALUOut, register file and inline ALU
module mc_datapath import mc_datapath_pkg::*; #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  mc_datapath_if.slave  bus
);

  logic [DATA_W-1:0] pc, ir, mdr, a_reg, b_reg, alu_out;
  logic [DATA_W-1:0] imm_ext, src_a, src_b, alu_result, pc_next;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic [4:0]        rf_waddr;

  assign imm_ext = sext16(ir[15:0]);

  always_comb begin
    src_a = bus.ALUSrcA ? a_reg : pc;
    src_b = b_reg;
    case (bus.ALUSrcB)
      SRCB_REG:    src_b = b_reg;
      SRCB_FOUR:   src_b = 32'd4;
      SRCB_IMM:    src_b = imm_ext;
      SRCB_IMM_SH: src_b = {imm_ext[DATA_W-3:0], 2'b00};
      default:     src_b = b_reg;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (bus.ALUOperation)
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  // Jump target uses the already-incremented PC for its upper nibble.
  always_comb begin
    pc_next = alu_result;
    case (bus.PCSrc)
      PCSRC_ALU:    pc_next = alu_result;
      PCSRC_ALUOUT: pc_next = alu_out;
      PCSRC_JUMP:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      PCSRC_REG:    pc_next = a_reg;
      default:      pc_next = alu_result;
    endcase
  end

  always_comb begin
    rf_waddr = bus.RegDst ? ir[15:11] : ir[20:16];
    if (bus.JalSig1) rf_waddr = REG_RA;
    rf_wdata = bus.MemToReg ? mdr : alu_out;
    if (bus.JalSig2) rf_wdata = pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= PC_RESET;
      ir      <= '0;
      mdr     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
    end else begin
      mdr     <= bus.mem_rdata;
      a_reg   <= rf_rdata_a;
      b_reg   <= rf_rdata_b;
      alu_out <= alu_result;
      if (bus.IRWrite) ir <= bus.mem_rdata;
      if (bus.PCLoad)  pc <= pc_next;
    end
  end

  mc_regfile u_rf (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (ir[25:21]),
    .raddr_b (ir[20:16]),
    .we      (bus.RegWrite),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b)
  );

  assign bus.mem_addr  = bus.IorD ? alu_out : pc;
  assign bus.mem_wdata = b_reg;
  assign bus.opc       = ir[31:26];
  assign bus.func      = ir[5:0];
  assign bus.zero      = (alu_result == '0);

endmodule

// File: tb/tb_mc_datapath.sv
// tb/tb_mc_datapath.sv - self-checking bench for mc_datapath against an instruction-level reference model
module tb_mc_datapath;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  mc_datapath_if bus();

  mc_datapath #(.PC_RESET(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_out;
  logic [31:0] m_rf [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_imm();
    logic [31:0] v;
    v = {16'h0000, m_ir[15:0]};
    if (m_ir[15]) v = v - 32'h0001_0000;
    return v;
  endfunction

  function automatic logic [31:0] m_alu();
    logic [31:0] x, y;
    x = bus.ALUSrcA ? m_a : m_pc;
    case (bus.ALUSrcB)
      2'd0: y = m_b;
      2'd1: y = 32'd4;
      2'd2: y = m_imm();
      default: y = m_imm() * 32'd4;
    endcase
    case (bus.ALUOperation)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x + y;
      3'd6: return x - y;
      3'd7: return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_out = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
  endtask

  task automatic model_edge();
    logic [31:0] res, npc, wd, na, nb;
    int wa;
    res = m_alu();
    case (bus.PCSrc)
      2'd0: npc = res;
      2'd1: npc = m_out;
      2'd2: npc = (m_pc & 32'hF000_0000) + (m_ir & 32'h03FF_FFFF) * 4;
      default: npc = m_a;
    endcase
    wa = bus.JalSig1 ? 31 : (bus.RegDst ? int'(m_ir[15:11]) : int'(m_ir[20:16]));
    wd = bus.JalSig2 ? m_pc : (bus.MemToReg ? m_mdr : m_out);
    na = m_rf[m_ir[25:21]];
    nb = m_rf[m_ir[20:16]];
    if (bus.RegWrite && wa != 0) m_rf[wa] = wd;
    m_a = na; m_b = nb; m_out = res; m_mdr = bus.mem_rdata;
    if (bus.IRWrite) m_ir = bus.mem_rdata;
    if (bus.PCLoad) m_pc = npc;
  endtask

  task automatic compare_all();
    chk("mem_addr",  bus.mem_addr,  bus.IorD ? m_out : m_pc);
    chk("mem_wdata", bus.mem_wdata, m_b);
    chk("opc",       {26'h0, bus.opc},  m_ir >> 26);
    chk("func",      {26'h0, bus.func}, m_ir & 32'h3F);
    chk("zero",      {31'h0, bus.zero}, (m_alu() == 32'h0) ? 32'd1 : 32'd0);
  endtask

  // Inputs are set just after a falling edge; compare, take the rising edge, return at the next falling edge.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    if (rst) model_edge(); else model_reset();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.PCLoad = 0; bus.IorD = 0; bus.IRWrite = 0; bus.RegDst = 0;
    bus.JalSig1 = 0; bus.JalSig2 = 0; bus.MemToReg = 0; bus.RegWrite = 0;
    bus.ALUSrcA = 0; bus.ALUSrcB = 2'd0; bus.ALUOperation = 3'd0; bus.PCSrc = 2'd0;
    bus.mem_rdata = 32'h0;
  endtask

  task automatic load_ir(input logic [31:0] w);
    idle(); bus.mem_rdata = w; bus.IRWrite = 1; tick(); idle();
  endtask

  task automatic addi_wb();
    idle(); tick();
    bus.ALUSrcA = 1; bus.ALUSrcB = 2'd2; bus.ALUOperation = 3'd2; tick();
    idle(); bus.RegWrite = 1; tick(); idle();
  endtask

  initial begin
    logic [31:0] w;
    idle();
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1;
    #1;
    chk("reset mem_addr",  bus.mem_addr, 32'h0);
    chk("reset opc",       {26'h0, bus.opc}, 32'h0);
    chk("reset func",      {26'h0, bus.func}, 32'h0);
    chk("reset mem_wdata", bus.mem_wdata, 32'h0);

    // fetch of addi $8,$0,5
    idle(); bus.mem_rdata = 32'h2008_0005; bus.IRWrite = 1; bus.ALUSrcB = 2'd1;
    bus.ALUOperation = 3'd2; bus.PCLoad = 1; tick(); idle(); #1;
    chk("fetch mem_addr", bus.mem_addr, 32'h4);
    chk("fetch opc", {26'h0, bus.opc}, 32'h08);
    chk("model pc", m_pc, 32'h4);
    tick();
    bus.ALUSrcA = 1; bus.ALUSrcB = 2'd2; bus.ALUOperation = 3'd2; #1;
    chk("addi zero", {31'h0, bus.zero}, 32'h0);
    tick(); idle(); bus.IorD = 1; #1;
    chk("addi aluout", bus.mem_addr, 32'h5);
    idle(); bus.RegWrite = 1; tick(); idle(); #1;
    chk("no bypass", bus.mem_wdata, 32'h0);
    tick(); #1;
    chk("reg8 written", bus.mem_wdata, 32'h5);
    chk("model reg8", m_rf[8], 32'h5);

    load_ir(32'h2000_0009); addi_wb(); tick(); #1;
    chk("r0 stays zero", bus.mem_wdata, 32'h0);

    load_ir(32'h2009_0007); addi_wb();
    load_ir(32'h200A_0007); addi_wb();
    load_ir(32'h200B_0008); addi_wb();
    load_ir(32'h112A_0000); tick();
    bus.ALUSrcA = 1; bus.ALUOperation = 3'd6; #1;
    chk("beq equal zero", {31'h0, bus.zero}, 32'h1);
    load_ir(32'h112B_0000); tick();
    bus.ALUSrcA = 1; bus.ALUOperation = 3'd6; #1;
    chk("beq differ zero", {31'h0, bus.zero}, 32'h0);
    tick(); idle(); bus.IorD = 1; #1;
    chk("sub result", bus.mem_addr, 32'hFFFF_FFFF);

    load_ir(32'h0800_0004); bus.PCSrc = 2'd2; bus.PCLoad = 1; tick(); idle(); #1;
    chk("jump pc", bus.mem_addr, 32'h10);
    load_ir(32'h0C00_0040);
    bus.JalSig1 = 1; bus.JalSig2 = 1; bus.RegWrite = 1; bus.PCSrc = 2'd2; bus.PCLoad = 1;
    tick(); idle(); #1;
    chk("jal pc", bus.mem_addr, 32'h100);
    load_ir(32'h001F_0000); tick(); #1;
    chk("jal ra", bus.mem_wdata, 32'h10);

    load_ir(32'h8C0C_0020); tick();
    bus.ALUSrcA = 1; bus.ALUSrcB = 2'd2; bus.ALUOperation = 3'd2; tick();
    idle(); bus.IorD = 1; #1;
    chk("lw addr", bus.mem_addr, 32'h20);
    bus.mem_rdata = 32'hDEAD_BEEF; tick();
    idle(); bus.MemToReg = 1; bus.RegWrite = 1; tick(); idle(); tick(); #1;
    chk("lw data", bus.mem_wdata, 32'hDEAD_BEEF);

    load_ir(32'h0800_0010); bus.PCSrc = 2'd2; bus.PCLoad = 1; tick(); idle(); #1;
    chk("pre-reset pc", dut.pc, 32'h40);
    chk("pre-reset reg8", dut.u_rf.regs[8], 32'h5);
    rst = 0; #1;
    chk("async reset pc", bus.mem_addr, 32'h0);
    chk("async reset reg8", dut.u_rf.regs[8], 32'h0);
    chk("async reset opc", {26'h0, bus.opc}, 32'h0);
    model_reset();
    rst = 1;

    for (int n = 0; n < 600; n++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w = w & ~32'h0318_0000;
      bus.mem_rdata = w;
      bus.PCLoad = 1'($urandom_range(0, 1));
      bus.IorD = 1'($urandom_range(0, 1));
      bus.IRWrite = 1'($urandom_range(0, 1));
      bus.RegDst = 1'($urandom_range(0, 1));
      bus.JalSig1 = ($urandom_range(0, 7) == 0);
      bus.JalSig2 = ($urandom_range(0, 7) == 0);
      bus.MemToReg = 1'($urandom_range(0, 1));
      bus.RegWrite = 1'($urandom_range(0, 1));
      bus.ALUSrcA = 1'($urandom_range(0, 1));
      bus.ALUSrcB = 2'($urandom_range(0, 3));
      bus.ALUOperation = 3'($urandom_range(0, 7));
      bus.PCSrc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        bus.ALUSrcA = 1; bus.ALUSrcB = 2'd0; bus.ALUOperation = 3'd6;
      end
      if ($urandom_range(0, 63) == 0) begin
        rst = 0; #1; model_reset(); rst = 1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
Multicycle MIPS datapath: the consumer of the control bundle produced by the multicycle controller, and the producer of opc/func/zero back to it.
Holds the architectural PC, the 32x32 register file and the inter-cycle registers (IR, MDR, A, B, ALUOut).
Sits between the controller and a single unified instruction/data memory, which is external and combinational-read.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low (0 = reset asserted)
PCLoad  in  1  PC write enable (already resolved for beq/bne)
IorD  in  1  memory address select: 0 = PC, 1 = ALUOut
IRWrite  in  1  IR load enable
RegDst  in  1  write-register select: 0 = rt, 1 = rd
JalSig1  in  1  1 = write register forced to 31
JalSig2  in  1  1 = write data is PC (return address)
MemToReg  in  1  write data select: 0 = ALUOut, 1 = MDR
RegWrite  in  1  register-file write enable
ALUSrcA  in  1  ALU A operand: 0 = PC, 1 = A
ALUSrcB  in  2  ALU B operand: 00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2
ALUOperation  in  3  ALU function: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed)
PCSrc  in  2  next-PC source: 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28],IR[25:0],2'b00}, 11 = A
mem_rdata  in  32  memory read data (combinational on mem_addr)
mem_addr  out  32  memory byte address
mem_wdata  out  32  store data, always equal to B
opc  out  6  IR[31:26]
func  out  6  IR[5:0]
zero  out  1  combinational; 1 when the current ALU result == 0

Behaviour:
- Reset (rst low, asynchronous):
  - PC = PC_RESET.
  - IR, MDR, A, B, ALUOut = 0.
  - All 32 registers = 0.
  - Resulting outputs: opc = 0, func = 0, mem_addr = PC_RESET, mem_wdata = 0.
- Reset asserted mid-instruction discards all in-flight state. The first post-reset edge behaves as a clean fetch.
- Every rising edge:
  - MDR <= mem_rdata.
  - A <= reg[IR[25:21]], B <= reg[IR[20:16]], both read from the current (pre-edge) IR.
  - ALUOut <= current ALU result.
  - IR <= mem_rdata only if IRWrite.
  - PC <= PCSrc-selected value only if PCLoad.
- Register-file write: on the edge when RegWrite = 1.
  - Address: 31 if JalSig1, else rd if RegDst, else rt. JalSig1 overrides RegDst.
  - Data: PC if JalSig2, else MDR if MemToReg, else ALUOut. JalSig2 overrides MemToReg.
- Register 0 reads as 0 always; writes to it are dropped.
- Read-during-write to the same register: A/B capture the old value; the new value is visible from the next edge on. No bypass.
- Immediate is sign-extended from IR[15:0] for all uses, including andi.
- ALU:
  - All arithmetic is 32-bit modulo 2^32; no overflow trap.
  - SLT yields 32'd1 or 32'd0, signed compare.
  - Unlisted ALUOperation codes yield 0.
- Jump target uses the current PC, which was already incremented during fetch.
- IorD = 1 with ALUOut unaligned: the address is passed through unmodified; alignment is the memory's concern.
- Latency:
  - zero, mem_addr and opc/func are valid in the same cycle as their inputs (purely combinational from registers and controls).
  - Architectural updates are one edge after the control is asserted.

Decomposition:
- Shared package: ALUOperation codes, ALUSrcB/PCSrc encodings, register index 31 constant, and the width 32.
- One natural sub-module: mc_regfile (32x32, two async read ports, one sync write port, async active-low reset, r0 hardwired). The ALU stays inline.

Test Plan:
- Reset then fetch: rst low, then high. mem_rdata = 32'h2008_0005; IRWrite = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOperation = 010, PCSrc = 00, PCLoad = 1 -> after the edge, PC = 4, opc = 6'h08, mem_addr = 4.
- addi writeback: with IR above, next cycles ALUSrcA = 1, ALUSrcB = 10, ADD, then RegWrite = 1, RegDst = 0, MemToReg = 0 -> reg[8] = 5. A write with IR rt = 0 leaves reg[0] reading 0.
- beq compare: A = B = 7, ALUSrcA = 1, ALUSrcB = 00, SUB -> zero = 1. With A = 7, B = 8 -> zero = 0 and the SUB result = 32'hFFFF_FFFF.
- jal: PC = 32'h0000_0010, IR[25:0] = 26'h40, JalSig1 = JalSig2 = RegWrite = 1, PCSrc = 10, PCLoad = 1 -> reg[31] = 32'h10, PC = 32'h100.
- lw/sw: ALUOut = 32'h20, IorD = 1 -> mem_addr = 32'h20. mem_rdata = 32'hDEAD_BEEF, then MemToReg = 1, RegWrite = 1 to rt -> the register holds DEADBEEF. mem_wdata tracks B.
- Async reset mid-instruction: assert rst low between edges with PC = 32'h40 and reg[8] = 5 -> PC = 0 and reg[8] = 0 immediately, with no clock edge required.
